// File: rtl/mau_host_sequencer.sv
// mau_host_sequencer: parses host command packets and sequences load/store traffic into the matrix algebra unit
module mau_host_sequencer #(
  parameter int         MATRIX_DIM  = 8,
  parameter int         RD_LAT      = 2,
  parameter logic [1:0] LOAD_CLASS  = 2'b01,
  parameter logic [1:0] STORE_CLASS = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] mau_instr,
  output logic [7:0] mau_data_in,
  input  logic [7:0] mau_data_out,
  input  logic       mau_busy,
  output logic       cmd_done
);
  localparam int BYTES = MATRIX_DIM * MATRIX_DIM;
  localparam int IW = $clog2(BYTES + 1);
  localparam int AW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);
  typedef enum logic [3:0] {
    IDLE, PAYLOAD, WAIT_RDY, ISSUE, STREAM, CAP_WAIT, CAPTURE, WAIT_DONE, DRAIN
  } state_t;
  state_t        state;
  logic [7:0]    cmd;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          first;
  logic [7:0]    mem [BYTES];
  logic [AW-1:0] pos, pos_nx;
  logic [7:0]    rd_nx, wr_data;
  logic          accept, last, is_load, is_store, wr_en;
  assign pos      = idx[AW-1:0];
  assign pos_nx   = pos + AW'(1);
  assign rd_nx    = mem[pos_nx];
  assign accept   = s_valid & s_ready;
  assign last     = idx == LAST;
  assign is_load  = cmd[7:6] == LOAD_CLASS;
  assign is_store = cmd[7:6] == STORE_CLASS;
  // Shared buffer is written by host payload bytes or by unit read-back, never both at once
  always_comb begin
    wr_en   = (state == PAYLOAD && accept) || state == CAPTURE;
    wr_data = state == CAPTURE ? mau_data_out : s_data;
  end
  // Buffer storage; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk)
    if (wr_en) mem[pos] <= wr_data;
  // Command FSM; every output is registered and driven from the transition taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= 8'h00;
      idx         <= '0;
      cnt         <= '0;
      first       <= 1'b0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= 8'h00;
      mau_instr   <= 8'h00;
      mau_data_in <= 8'h00;
      cmd_done    <= 1'b0;
    end else begin
      cmd_done    <= 1'b0;
      mau_instr   <= 8'h00;
      mau_data_in <= 8'h00;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept && s_data != 8'h00) begin
            cmd <= s_data;
            idx <= '0;
            if (s_data[7:6] == LOAD_CLASS) state <= PAYLOAD;
            else begin
              state   <= WAIT_RDY;
              s_ready <= 1'b0;
            end
          end
        end
        PAYLOAD:
          if (accept) begin
            idx <= idx + IW'(1);
            if (last) begin
              state   <= WAIT_RDY;
              s_ready <= 1'b0;
            end
          end
        WAIT_RDY:
          if (!mau_busy) begin
            state     <= ISSUE;
            mau_instr <= cmd;
          end
        ISSUE: begin
          idx <= '0;
          if (is_load) begin
            state       <= STREAM;
            mau_data_in <= mem[0];
          end else if (is_store) begin
            if (RD_LAT <= 1) state <= CAPTURE;
            else begin
              state <= CAP_WAIT;
              cnt   <= CW'(RD_LAT - 1);
            end
          end else begin
            state <= WAIT_DONE;
            first <= 1'b1;
          end
        end
        STREAM:
          if (last) begin
            state <= WAIT_DONE;
            first <= 1'b1;
          end else begin
            idx         <= idx + IW'(1);
            mau_data_in <= rd_nx;
          end
        CAP_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) state <= CAPTURE;
        end
        CAPTURE:
          if (last) begin
            state <= WAIT_DONE;
            first <= 1'b1;
          end else idx <= idx + IW'(1);
        WAIT_DONE:
          if (first) first <= 1'b0;
          else if (!mau_busy) begin
            if (is_store) begin
              state   <= DRAIN;
              idx     <= '0;
              m_valid <= 1'b1;
              m_data  <= mem[0];
            end else begin
              state    <= IDLE;
              cmd_done <= 1'b1;
              s_ready  <= 1'b1;
            end
          end
        DRAIN:
          if (m_ready) begin
            if (last) begin
              state    <= IDLE;
              m_valid  <= 1'b0;
              cmd_done <= 1'b1;
              s_ready  <= 1'b1;
            end else begin
              idx    <= idx + IW'(1);
              m_data <= rd_nx;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mau_host_sequencer.sv
// tb_mau_host_sequencer: randomized scenario bench with a behavioural host/unit model
module tb_mau_host_sequencer;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] s_data = 8'h00, m_data, mau_instr, mau_data_in, mau_data_out = 8'h00;
  logic       s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, mau_busy = 1'b0, cmd_done;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mau_host_sequencer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .mau_instr(mau_instr),
    .mau_data_in(mau_data_in), .mau_data_out(mau_data_out), .mau_busy(mau_busy),
    .cmd_done(cmd_done)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Offers one byte to the host port until accepted; returns aligned just after a rising edge
  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_data  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // Unit model for a store: read-back byte i is A0+i, first byte RD_LAT=2 cycles after the instruction
  task automatic mau_respond(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = mau_instr == 8'h82;
    end
    @(posedge clk);
    if (ok) begin
      @(posedge clk); #1;
      for (int i = 0; i < 64; i++) begin
        mau_data_out = 8'(8'hA0 + i);
        @(posedge clk); #1;
      end
      mau_data_out = 8'h00;
    end else #1;
  endtask

  task automatic test_reset;
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_ready, m_valid, cmd_done, mau_instr, mau_data_in, m_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got s_ready=%b m_valid=%b cmd_done=%b instr=%h din=%h m_data=%h, expected all 0",
               s_ready, m_valid, cmd_done, mau_instr, mau_data_in, m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = s_ready === 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL reset_release_s_ready: got %b expected 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_load;
    logic [7:0] pl [64];
    bit ok, all_ok, found;
    int pulses;
    for (int i = 0; i < 64; i++) pl[i] = 8'(i);
    send_byte(8'h41, 1'b1, all_ok);
    for (int i = 0; i < 64; i++) begin
      send_byte(pl[i], 1'b1, ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok) begin n_fail++; $display("FAIL load_accept: got %b expected 1", all_ok); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = mau_instr !== 8'h00;
    end
    n_checks++;
    if (mau_instr !== 8'h41) begin n_fail++; $display("FAIL load_instr: got %h expected 41", mau_instr); end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_checks++;
      if (mau_data_in !== pl[i] || mau_instr !== 8'h00) begin
        n_fail++;
        $display("FAIL load_stream[%0d]: got din=%h instr=%h expected din=%h instr=00", i, mau_data_in, mau_instr, pl[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (mau_data_in !== 8'h00) begin n_fail++; $display("FAIL load_din_idle: got %h expected 00", mau_data_in); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pulses += int'(cmd_done);
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL load_cmd_done: got %0d pulses expected 1", pulses); end
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL load_back_idle: got s_ready=%b expected 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    bit ok, resp_ok, stalled;
    int got;
    logic [7:0] held, exp;
    send_byte(8'h82, 1'b0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL store_accept: got %b expected 1", ok); end
    got = 0;
    stalled = 1'b0;
    held = 8'h00;
    fork
      mau_respond(resp_ok);
      for (int c = 0; c < 3000 && got < 64; c++) begin
        m_ready = ($urandom % 3) != 0;
        @(negedge clk);
        if (stalled) begin
          n_checks++;
          if (m_valid !== 1'b1 || m_data !== held) begin
            n_fail++;
            $display("FAIL store_hold: got valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, held);
          end
        end
        stalled = 1'b0;
        if (m_valid && m_ready) begin
          exp = 8'(8'hA0 + got);
          n_checks++;
          if (m_data !== exp) begin n_fail++; $display("FAIL store_data[%0d]: got %h expected %h", got, m_data, exp); end
          got++;
        end else if (m_valid) begin
          stalled = 1'b1;
          held = m_data;
        end
        @(posedge clk); #1;
      end
    join
    m_ready = 1'b0;
    n_checks++;
    if (!resp_ok) begin n_fail++; $display("FAIL store_issue: got no 82 instruction expected one"); end
    n_checks++;
    if (got != 64) begin n_fail++; $display("FAIL store_count: got %0d bytes expected 64", got); end
    @(negedge clk);
    n_checks++;
    if (cmd_done !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_cmd_done: got cmd_done=%b m_valid=%b expected 1 0", cmd_done, m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy;
    bit ok, found;
    int bad;
    mau_busy = 1'b1;
    send_byte(8'hC3, 1'b0, ok);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mau_instr !== 8'h00) bad++;
    end
    n_checks++;
    if (!ok || bad != 0) begin n_fail++; $display("FAIL busy_hold: got accept=%b early_issues=%0d expected 1 0", ok, bad); end
    @(posedge clk); #1;
    mau_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      found = mau_instr !== 8'h00;
    end
    n_checks++;
    if (mau_instr !== 8'hC3) begin n_fail++; $display("FAIL busy_issue: got %h expected c3", mau_instr); end
    @(negedge clk);
    n_checks++;
    if (mau_instr !== 8'h00) begin n_fail++; $display("FAIL busy_pulse_width: got %h expected 00", mau_instr); end
    @(posedge clk); #1;
    mau_busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    mau_busy = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL busy_done_early: got %0d done cycles expected 0", bad); end
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      found = cmd_done === 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL busy_done: got no cmd_done expected one"); end
    @(posedge clk); #1;
  endtask

  task automatic test_nop_flow;
    logic [7:0] pl [64];
    logic [7:0] exp;
    bit ok, all_ok, found;
    int bad, got;
    send_byte(8'h00, 1'b0, ok);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mau_instr !== 8'h00 || cmd_done !== 1'b0 || s_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (!ok || bad != 0) begin n_fail++; $display("FAIL nop: got accept=%b activity_cycles=%0d expected 1 0", ok, bad); end
    @(posedge clk); #1;
    send_byte(8'h82, 1'b0, ok);
    mau_respond(all_ok);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = m_valid === 1'b1;
    end
    n_checks++;
    if (!found || !ok || !all_ok) begin n_fail++; $display("FAIL flow_drain_start: got m_valid=%b expected 1", m_valid); end
    @(posedge clk); #1;
    s_data = 8'h41;
    s_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hA0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL flow_stall: got %0d bad stall cycles expected 0", bad); end
    m_ready = 1'b1;
    got = 0;
    bad = 0;
    for (int c = 0; c < 200 && got < 64; c++) begin
      @(negedge clk);
      if (s_ready !== 1'b0) bad++;
      if (m_valid) begin
        exp = 8'(8'hA0 + got);
        n_checks++;
        if (m_data !== exp) begin n_fail++; $display("FAIL flow_data[%0d]: got %h expected %h", got, m_data, exp); end
        got++;
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    n_checks++;
    if (bad != 0 || got != 64) begin n_fail++; $display("FAIL flow_drain: got %0d bytes, %0d ready cycles expected 64 0", got, bad); end
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1 || cmd_done !== 1'b1) begin
      n_fail++;
      $display("FAIL flow_take_after_idle: got s_ready=%b cmd_done=%b expected 1 1", s_ready, cmd_done);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pl[i] = 8'($urandom);
      send_byte(pl[i], 1'b1, ok);
      all_ok &= ok;
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = mau_instr !== 8'h00;
    end
    n_checks++;
    if (!all_ok || mau_instr !== 8'h41) begin n_fail++; $display("FAIL flow_load_instr: got %h expected 41", mau_instr); end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (mau_data_in !== pl[i]) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL flow_load_stream: got %0d wrong bytes expected 0", bad); end
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stream;
    logic [7:0] pl [64];
    bit ok, all_ok, found;
    send_byte(8'h41, 1'b0, all_ok);
    for (int i = 0; i < 64; i++) begin
      pl[i] = 8'($urandom_range(1, 255));
      send_byte(pl[i], 1'b0, ok);
      all_ok &= ok;
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = mau_instr === 8'h41;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (!all_ok || !found || mau_data_in !== pl[4]) begin
      n_fail++;
      $display("FAIL rst_pre_stream: got din=%h expected %h", mau_data_in, pl[4]);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mau_instr, mau_data_in, s_ready, m_valid} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got instr=%h din=%h s_ready=%b m_valid=%b expected 0", mau_instr, mau_data_in, s_ready, m_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mau_instr, mau_data_in, s_ready, m_valid, cmd_done} !== '0) begin
      n_fail++;
      $display("FAIL rst_next_edge: got instr=%h din=%h s_ready=%b m_valid=%b expected 0", mau_instr, mau_data_in, s_ready, m_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      found = s_ready === 1'b1;
    end
    n_checks++;
    if (!found || mau_data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_release: got s_ready=%b din=%h expected 1 00", s_ready, mau_data_in);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_busy();
    test_nop_flow();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
